// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared CPU constants for the hazard/stall controller.
// Provides Tuse/Tnew stage encodings, multiply/divide latencies, the
// producer record type and the helpers used by the hazard compare.
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int STAGE_W    = 2;

  // Tuse: the stage in which the D instruction consumes an operand.
  localparam logic [STAGE_W-1:0] TUSE_D = 2'd0;
  localparam logic [STAGE_W-1:0] TUSE_E = 2'd1;
  localparam logic [STAGE_W-1:0] TUSE_M = 2'd2;

  // Tnew: cycles, counted from E, until a producer's result exists.
  localparam logic [STAGE_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [STAGE_W-1:0] TNEW_ONE  = 2'd1;
  localparam logic [STAGE_W-1:0] TNEW_TWO  = 2'd2;

  // Multiply/divide unit occupancy in cycles.
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;
  localparam int MD_CNT_W       = 4;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_e;

  // One in-flight producer: does it write, where, and when is the value ready.
  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] a3;
    logic [STAGE_W-1:0]    tnew;
  } prod_rec_t;

  // Tnew one stage later; zero stays zero.
  function automatic logic [STAGE_W-1:0] tnew_dec(input logic [STAGE_W-1:0] tnew);
    return (tnew == TNEW_NONE) ? TNEW_NONE : tnew - 1'b1;
  endfunction

  // True when this record will not have produced src by the time it is needed.
  // $0 is never a real dependency, and non-writing records never block.
  function automatic logic rec_blocks(input prod_rec_t             rec,
                                      input logic [REG_ADDR_W-1:0] src,
                                      input logic [STAGE_W-1:0]    tuse);
    return rec.reg_write && (rec.a3 != '0) && (src != '0) &&
           (src == rec.a3) && (rec.tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_cnt.sv
// md_busy_cnt: multiply/divide occupancy counter.
// Present only when HAZARD_MD_STALL_EN is defined. Loads the op latency on
// the edge after start, then counts down to zero and holds there.
`ifdef HAZARD_MD_STALL_EN
module md_busy_cnt
  import hazard_stall_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  md_op_e              op,
  output logic [MD_CNT_W-1:0] count,
  output logic                busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MD_MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(MD_DIV_CYCLES);

  // Reload on start (a start while busy simply restarts), else count down to 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= (op == MD_DIV) ? DIV_LOAD : MULT_LOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule
`endif

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew hazard detection and stall generation.
// Tracks E and M producer records, compares them against the D stage
// sources and raises a zero-latency stall. Stalls drop a bubble into E.
// Optional feature macro: HAZARD_MD_STALL_EN enables the multiply/divide
// busy tracking (md_busy_cnt) and the HI/LO use stall.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] D_rs,
  input  logic [REG_ADDR_W-1:0] D_rt,
  input  logic [STAGE_W-1:0]    D_Tuse_rs,
  input  logic [STAGE_W-1:0]    D_Tuse_rt,
  input  logic                  D_RegWrite,
  input  logic [REG_ADDR_W-1:0] D_RegA3,
  input  logic [STAGE_W-1:0]    D_Tnew,
  input  logic                  D_mdStart,
  input  logic                  D_mdOp,
  input  logic                  D_useMD,
  output logic                  stall,
  output logic                  E_RegWrite,
  output logic [REG_ADDR_W-1:0] E_RegA3,
  output logic                  M_RegWrite,
  output logic [REG_ADDR_W-1:0] M_RegA3,
  output logic                  md_busy
);

  prod_rec_t d_rec;
  prod_rec_t e_rec;
  prod_rec_t m_rec;
  logic      rs_conflict;
  logic      rt_conflict;
  logic      md_conflict;

  assign d_rec = '{reg_write: D_RegWrite, a3: D_RegA3, tnew: D_Tnew};

  // Register-operand conflicts against both in-flight producers.
  always_comb begin
    rs_conflict = rec_blocks(e_rec, D_rs, D_Tuse_rs) |
                  rec_blocks(m_rec, D_rs, D_Tuse_rs);
    rt_conflict = rec_blocks(e_rec, D_rt, D_Tuse_rt) |
                  rec_blocks(m_rec, D_rt, D_Tuse_rt);
  end

  assign stall = rs_conflict | rt_conflict | md_conflict;

  // Producer pipeline: D->E (bubble on stall), E->M with Tnew aged by one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_rec <= '0;
      m_rec <= '0;
    end else begin
      e_rec <= stall ? prod_rec_t'('0) : d_rec;
      m_rec <= '{reg_write: e_rec.reg_write, a3: e_rec.a3,
                 tnew: tnew_dec(e_rec.tnew)};
    end
  end

  assign E_RegWrite = e_rec.reg_write;
  assign E_RegA3    = e_rec.a3;
  assign M_RegWrite = m_rec.reg_write;
  assign M_RegA3    = m_rec.a3;

`ifdef HAZARD_MD_STALL_EN
  logic                e_md_start;
  md_op_e              e_md_op;
  logic [MD_CNT_W-1:0] md_count;

  // Mult/div issue travels into E with its op; a bubble cancels it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_md_start <= 1'b0;
      e_md_op    <= MD_MULT;
    end else if (stall) begin
      e_md_start <= 1'b0;
      e_md_op    <= MD_MULT;
    end else begin
      e_md_start <= D_mdStart;
      e_md_op    <= md_op_e'(D_mdOp);
    end
  end

  md_busy_cnt u_md_busy_cnt (
    .clk   (clk),
    .reset (reset),
    .start (e_md_start),
    .op    (e_md_op),
    .count (md_count),
    .busy  (md_busy)
  );

  // HI/LO users wait while an op is issuing from E or still counting.
  assign md_conflict = D_useMD & (e_md_start | (md_count != '0));
`else
  logic unused_md_inputs;

  assign unused_md_inputs = D_mdStart ^ D_mdOp ^ D_useMD;
  assign md_conflict      = 1'b0;
  assign md_busy          = 1'b0;
`endif

endmodule
